// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction-memory request/ack bus between F stage and memory.
// master = fetch side, slave = memory side.
interface fetch_unit_if #(
  parameter int W = 32
) ();
  logic         instrreq;
  logic [W-1:0] instradr;
  logic         instrack;
  logic [W-1:0] instrF;
  logic         instrabort;

  modport master (
    output instrreq,
    output instradr,
    input  instrack,
    input  instrF,
    input  instrabort
  );

  modport slave (
    input  instrreq,
    input  instradr,
    output instrack,
    output instrF,
    output instrabort
  );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: MIPS F stage with handshaked fetch, timeout retry and prefetch queue.
// Optional macro FETCH_BYPASS_EN forwards an empty-queue ack to D in the same cycle.
module fetch_unit #(
  parameter int           W        = 32,
  parameter int           DEPTH    = 4,
  parameter int           MAXWAIT  = 8,
  parameter logic [W-1:0] RESET_PC = '0
) (
  input  logic         clk,
  input  logic         reset,
  fetch_unit_if.master mem,
  input  logic         stall,
  input  logic         redirect,
  input  logic [W-1:0] redirect_pc,
  output logic         instr_valid,
  output logic [W-1:0] instrD,
  output logic [W-1:0] pc4D,
  output logic [7:0]   pclow,
  output logic         fetch_err
);

  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = AW + 1;
  localparam int WCW = $clog2(MAXWAIT);

  localparam logic [CW-1:0]  FULL  = CW'(DEPTH);
  localparam logic [WCW-1:0] WLAST = WCW'(MAXWAIT - 1);
  localparam logic [W-1:0]   FOUR  = W'(4);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] REQ   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  logic [1:0]     state_q, state_d;
  logic [W-1:0]   pc_q, pc_d;
  logic [WCW-1:0] wait_q, wait_d;
  logic           err_q, err_d;

  logic [AW-1:0]  wr_q, rd_q;
  logic [CW-1:0]  count_q, count_d;
  logic [W-1:0]   q_instr [DEPTH];
  logic [W-1:0]   q_pc4   [DEPTH];

  logic [W-1:0]   pc4;
  logic           ack_req;
  logic           bypass;
  logic           head_v;
  logic           enq;
  logic           deq;

  assign pc4     = pc_q + FOUR;
  assign ack_req = (state_q == REQ) & mem.instrack;
  assign head_v  = (count_q != '0);

`ifdef FETCH_BYPASS_EN
  assign bypass = ~head_v & ack_req & ~redirect;
`else
  assign bypass = 1'b0;
`endif

  // A bypassed word that D consumes this cycle never occupies a slot
  assign enq = ack_req & ~redirect & ~(bypass & ~stall);
  assign deq = head_v & ~stall & ~redirect;

  // Occupancy after this edge; a redirect empties the queue outright
  always_comb begin
    count_d = count_q;
    if (redirect)
      count_d = '0;
    else
      count_d = count_q + CW'(enq) - CW'(deq);
  end

  // Request FSM, fetch address and unacknowledged-cycle watchdog
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    wait_d  = wait_q;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!redirect && count_q < FULL) begin
          state_d = REQ;
          wait_d  = '0;
        end
      end
      REQ: begin
        if (redirect) begin
          state_d = DRAIN;
          wait_d  = '0;
        end else if (mem.instrack) begin
          pc_d   = pc4;
          wait_d = '0;
          if (count_d == FULL)
            state_d = IDLE;
        end else if (mem.instrabort) begin
          state_d = IDLE;
          wait_d  = '0;
        end else if (wait_q == WLAST) begin
          state_d = IDLE;
          wait_d  = '0;
          err_d   = 1'b1;
        end else begin
          wait_d = wait_q + WCW'(1);
        end
      end
      DRAIN: begin
        if (mem.instrack || mem.instrabort) begin
          state_d = IDLE;
          wait_d  = '0;
        end else if (wait_q == WLAST) begin
          state_d = IDLE;
          wait_d  = '0;
          err_d   = 1'b1;
        end else begin
          wait_d = wait_q + WCW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        wait_d  = '0;
      end
    endcase
    if (redirect)
      pc_d = redirect_pc;
  end

  // Control state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      wait_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
    end
  end

  // Queue pointers and occupancy; pointers wrap naturally at DEPTH
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      count_q <= count_d;
      if (redirect) begin
        wr_q <= '0;
        rd_q <= '0;
      end else begin
        wr_q <= wr_q + AW'(enq);
        rd_q <= rd_q + AW'(deq);
      end
    end
  end

  // Queue storage; contents only observable through count_q
  always_ff @(posedge clk) begin
    if (enq) begin
      q_instr[wr_q] <= mem.instrF;
      q_pc4[wr_q]   <= pc4;
    end
  end

  assign mem.instrreq = (state_q == REQ);
  assign mem.instradr = pc_q;
  assign pclow        = pc_q[9:2];
  assign fetch_err    = err_q;
  assign instr_valid  = head_v | bypass;

  // Head of queue to D, bypassed word when enabled, else a nop
  always_comb begin
    instrD = '0;
    pc4D   = '0;
    if (head_v) begin
      instrD = q_instr[rd_q];
      pc4D   = q_pc4[rd_q];
    end else if (bypass) begin
      instrD = mem.instrF;
      pc4D   = pc4;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed checks of fetch_unit (default build, bypass off).
// Memory returns instradr ^ PAT so every delivered word identifies its address.
module tb_fetch_unit;

  localparam logic [31:0] PAT = 32'hA5A5_0000;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        ack;
  logic        abort;
  logic        instr_valid;
  logic [31:0] instrD;
  logic [31:0] pc4D;
  logic [7:0]  pclow;
  logic        fetch_err;

  int n_cmp;
  int n_err;

  fetch_unit_if #(.W(32)) bus ();

  assign bus.instrack   = ack;
  assign bus.instrabort = abort;
  assign bus.instrF     = bus.instradr ^ PAT;

  fetch_unit #(
    .W(32),
    .DEPTH(4),
    .MAXWAIT(8),
    .RESET_PC(32'h0)
  ) dut (
    .clk(clk),
    .reset(reset),
    .mem(bus),
    .stall(stall),
    .redirect(redirect),
    .redirect_pc(redirect_pc),
    .instr_valid(instr_valid),
    .instrD(instrD),
    .pc4D(pc4D),
    .pclow(pclow),
    .fetch_err(fetch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic rst_cycle;
    reset    = 1'b1;
    ack      = 1'b0;
    abort    = 1'b0;
    stall    = 1'b0;
    redirect = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    n_cmp       = 0;
    n_err       = 0;
    reset       = 1'b1;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    ack         = 1'b0;
    abort       = 1'b0;
    tick();
    tick();

    chk("rst_req", 32'(bus.instrreq), 32'd0);
    chk("rst_adr", bus.instradr, 32'd0);
    chk("rst_vld", 32'(instr_valid), 32'd0);
    chk("rst_ins", instrD, 32'd0);
    chk("rst_pc4", pc4D, 32'd0);
    chk("rst_err", 32'(fetch_err), 32'd0);

    // streaming with ack tied high
    reset = 1'b0;
    ack   = 1'b1;
    tick();
    chk("a_req", 32'(bus.instrreq), 32'd1);
    chk("a_adr0", bus.instradr, 32'd0);
    chk("a_vld0", 32'(instr_valid), 32'd0);
    tick();
    chk("a_adr4", bus.instradr, 32'd4);
    chk("a_vld1", 32'(instr_valid), 32'd1);
    chk("a_pc4", pc4D, 32'd4);
    chk("a_ins0", instrD, PAT);
    tick();
    chk("a_adr8", bus.instradr, 32'd8);
    chk("a_pc8", pc4D, 32'd8);
    chk("a_ins4", instrD, PAT ^ 32'd4);
    chk("a_pclow", 32'(pclow), 32'd2);
    tick();
    chk("a_adr12", bus.instradr, 32'd12);
    chk("a_pc12", pc4D, 32'd12);

    // stall fills the queue, then release drains in order
    stall = 1'b1;
    tick();
    tick();
    tick();
    chk("b_full", 32'(bus.instrreq), 32'd0);
    chk("b_head", pc4D, 32'd12);
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("b_hold_req", 32'(bus.instrreq), 32'd0);
      chk("b_hold_pc4", pc4D, 32'd12);
    end
    stall = 1'b0;
    chk("b_d0_pc4", pc4D, 32'd12);
    chk("b_d0_ins", instrD, PAT ^ 32'd8);
    tick();
    chk("b_d1_pc4", pc4D, 32'd16);
    chk("b_d1_req", 32'(bus.instrreq), 32'd0);
    tick();
    chk("b_d2_pc4", pc4D, 32'd20);
    chk("b_d2_req", 32'(bus.instrreq), 32'd1);
    chk("b_d2_adr", bus.instradr, 32'd24);
    tick();
    chk("b_d3_pc4", pc4D, 32'd24);
    chk("b_d3_ins", instrD, PAT ^ 32'd20);
    tick();
    chk("b_d4_pc4", pc4D, 32'd28);
    chk("b_d4_vld", 32'(instr_valid), 32'd1);

    // memory never acks: timeout every 9 cycles
    rst_cycle();
    for (int i = 1; i <= 19; i++) begin
      tick();
      chk("c_err", 32'(fetch_err), (i % 9 == 0) ? 32'd1 : 32'd0);
      chk("c_req", 32'(bus.instrreq), (i % 9 == 0) ? 32'd0 : 32'd1);
      chk("c_adr", bus.instradr, 32'd0);
      chk("c_vld", 32'(instr_valid), 32'd0);
    end

    // abort in third cycle of request to 0x10
    rst_cycle();
    ack = 1'b1;
    repeat (5) tick();
    chk("d_adr", bus.instradr, 32'h10);
    ack = 1'b0;
    tick();
    tick();
    abort = 1'b1;
    tick();
    chk("d_idle_req", 32'(bus.instrreq), 32'd0);
    chk("d_idle_adr", bus.instradr, 32'h10);
    chk("d_idle_vld", 32'(instr_valid), 32'd0);
    abort = 1'b0;
    tick();
    chk("d_re_req", 32'(bus.instrreq), 32'd1);
    chk("d_re_adr", bus.instradr, 32'h10);
    chk("d_re_vld", 32'(instr_valid), 32'd0);
    ack = 1'b1;
    tick();
    chk("d_ok_vld", 32'(instr_valid), 32'd1);
    chk("d_ok_pc4", pc4D, 32'h14);
    chk("d_ok_ins", instrD, PAT ^ 32'h10);

    // redirect with two queued and 0x20 outstanding
    rst_cycle();
    ack = 1'b1;
    repeat (8) tick();
    chk("e_adr1c", bus.instradr, 32'h1C);
    stall = 1'b1;
    tick();
    chk("e_adr20", bus.instradr, 32'h20);
    chk("e_vld", 32'(instr_valid), 32'd1);
    chk("e_head", pc4D, 32'h1C);
    ack         = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 32'h400;
    tick();
    redirect = 1'b0;
    chk("e_flush_vld", 32'(instr_valid), 32'd0);
    chk("e_drain_req", 32'(bus.instrreq), 32'd0);
    chk("e_drain_adr", bus.instradr, 32'h400);
    chk("e_pclow", 32'(pclow), 32'd0);
    ack   = 1'b1;
    stall = 1'b0;
    tick();
    chk("e_disc_vld", 32'(instr_valid), 32'd0);
    chk("e_disc_req", 32'(bus.instrreq), 32'd0);
    tick();
    chk("e_new_req", 32'(bus.instrreq), 32'd1);
    chk("e_new_adr", bus.instradr, 32'h400);
    chk("e_new_vld", 32'(instr_valid), 32'd0);
    tick();
    chk("e_out_vld", 32'(instr_valid), 32'd1);
    chk("e_out_pc4", pc4D, 32'h404);
    chk("e_out_ins", instrD, PAT ^ 32'h400);

    // async reset mid-REQ with three queued entries
    rst_cycle();
    stall = 1'b1;
    ack   = 1'b1;
    repeat (4) tick();
    chk("f_pre_vld", 32'(instr_valid), 32'd1);
    chk("f_pre_adr", bus.instradr, 32'hC);
    #3;
    reset = 1'b1;
    #1;
    chk("f_req", 32'(bus.instrreq), 32'd0);
    chk("f_adr", bus.instradr, 32'd0);
    chk("f_vld", 32'(instr_valid), 32'd0);
    chk("f_ins", instrD, 32'd0);
    chk("f_pc4", pc4D, 32'd0);
    chk("f_err", 32'(fetch_err), 32'd0);
    chk("f_pclow", 32'(pclow), 32'd0);
    tick();
    reset = 1'b0;
    stall = 1'b0;
    tick();
    chk("f_rs_req", 32'(bus.instrreq), 32'd1);
    chk("f_rs_adr", bus.instradr, 32'd0);
    tick();
    chk("f_rs_vld", 32'(instr_valid), 32'd1);
    chk("f_rs_pc4", pc4D, 32'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Parametrised instruction-fetch front end for the 5-stage MIPS pipeline.
- Replaces the fixed-count F-stage wait sequence with a handshaked memory request, a timeout/retry counter and a DEPTH-entry prefetch queue.
- Delivers {instruction, pc+4} to the D stage and honours decode stall and branch/jump redirect.

Parameters:
- W, 32, address and instruction width
- DEPTH, 4, prefetch queue entries (power of 2, ≥2)
- MAXWAIT, 8, cycles a request may stay unacknowledged before local retry (≥2)
- RESET_PC, 0, fetch address after reset

Ports:
- clk in 1 — rising-edge clock
- reset in 1 — asynchronous, active-high
- stall in 1 — D stage holds (StallD); no dequeue
- redirect in 1 — taken branch/jump in D
- redirect_pc in W — new fetch address
- instrreq out 1 — memory request valid
- instradr out W — request address
- instrack in 1 — instrF valid for the outstanding request
- instrF in W — returned instruction
- instrabort in 1 — memory rejects outstanding request
- instr_valid out 1 — instrD/pc4D valid
- instrD out W — head instruction, 0 (nop) when !instr_valid
- pc4D out W — address of head instruction + 4
- pclow out 8 — fetch_pc[9:2]
- fetch_err out 1 — one-cycle pulse on timeout

Behaviour:
- Reset (async):
  - fetch_pc = RESET_PC; queue empty; state IDLE.
  - instrreq = 0, instradr = RESET_PC, instr_valid = 0, instrD = 0, pc4D = 0, fetch_err = 0, wait counter = 0.
- At most one outstanding request. instradr = fetch_pc.
- FSM:
  - IDLE: if queue count + 1 ≤ DEPTH (slot free) and !redirect → REQ, instrreq = 1 next cycle.
  - REQ: instrreq held high, address stable.
    - instrack: enqueue {instrF, fetch_pc+4}; fetch_pc += 4; go IDLE if queue becomes full, otherwise stay in REQ with the next address (back-to-back, one fetch per cycle).
    - instrabort: drop the request, go to IDLE for 1 cycle, reissue same address.
    - Wait counter reaches MAXWAIT-1 without ack: pulse fetch_err, counter = 0, go to IDLE, reissue same address.
  - DRAIN: entered when redirect occurs while in REQ. instrreq deasserted. Wait for instrack or instrabort (or timeout) and discard it; then → IDLE.
- Wait counter: clears on every new request and on ack; counts cycles in REQ.
- Queue:
  - Circular, DEPTH entries; pointers wrap modulo DEPTH; count 0..DEPTH.
  - Dequeue when instr_valid & !stall.
  - Enqueue and dequeue in the same cycle while full is legal; count unchanged.
  - Never enqueue when full. A request is not issued unless a slot will be free at ack.
- Redirect, effective next edge:
  - Queue flushed; instr_valid = 0 the following cycle.
  - fetch_pc = redirect_pc.
  - FSM: REQ → DRAIN, IDLE stays IDLE.
  - Redirect wins over a simultaneous ack (data discarded), dequeue or abort.
  - Redirect during DRAIN updates fetch_pc only.
- Latency: ack at edge n → instr_valid at edge n+1 (queue registered).
- pc arithmetic is modulo 2^W; no alignment check.

Optional Feature:
- Macro FETCH_BYPASS_EN.
- Defined: when the queue is empty, instrack = 1, state REQ and !redirect, instrD = instrF and pc4D = fetch_pc+4 combinationally with instr_valid = 1 the same cycle.
  - If !stall, the word is consumed and not enqueued.
  - If stall, it is enqueued normally.
- Undefined: all data passes through the queue with 1-cycle latency.

Test Plan:
- Reset, instrack tied 1 from cycle 2, stall = 0 → instradr 0,4,8,… on consecutive cycles; instr_valid from the cycle after the first ack; pc4D = 4,8,12.
- stall = 1 for 10 cycles with always-ack (DEPTH = 4) → exactly 4 words enqueued, then instrreq = 0; on stall release, 4 consecutive instr_valid words in address order, no loss or duplication.
- Memory never acks (MAXWAIT = 8) → fetch_err pulses every 9 cycles (8 REQ + 1 IDLE); instradr stays 0; instr_valid = 0.
- instrabort in cycle 3 of a request to 0x10 → instrreq drops for 1 cycle, then reissues 0x10; no enqueue from the aborted request.
- redirect to 0x400 while a request to 0x20 is outstanding and the queue holds 2 entries → instr_valid = 0 next cycle; the ack for 0x20 is discarded; next request address = 0x400; first delivered pc4D = 0x404.
- Asynchronous reset asserted mid-REQ with 3 queued entries → all outputs return to reset values immediately, without waiting for a clock edge; after release, fetch restarts at RESET_PC.
